captura_pedidos: RTL and testbench
==================================

# captura_pedidos

Input front end for the two-station function selector. It synchronizes and debounces each station's raw switches and push-buttons (IE01: CH7..CH4, B3, B2; IE02: CH3..CH0, B1, B0). On each button press it captures a request word {profile, function} and presents it to the priority/arbitration logic through a REQ/ACK handshake. The block is the requesting side of the request path that the priority controller and display encoders consume; it replaces the direct switch-to-logic wiring.

## Interface
Parameters:
- DEB_CYCLES, 50000, consecutive stable cycles needed to accept a new button level (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- CLK  in  1  single system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PERF_IE01  in  3  raw profile switches {CH7,CH6,CH5}.
- SEL_IE01  in  1  raw function-bank switch CH4.
- BTN_IE01  in  2  raw buttons {B3,B2}, active-low (0 = pressed).
- PERF_IE02, SEL_IE02, BTN_IE02  in  3/1/2  same for {CH3,CH2,CH1}, CH0, {B1,B0}.
- REQ_IE01, REQ_IE02  out  1  request pending.
- PERF_OUT_IE01, PERF_OUT_IE02  out  3  latched profile, valid while REQ high.
- FUN_OUT_IE01, FUN_OUT_IE02  out  3  latched function code, valid while REQ high.
- ACK_IE01, ACK_IE02  in  1  arbiter acceptance, synchronous to CLK.
- ERR_IE01, ERR_IE02  out  1  one-cycle pulse: press rejected (profile 000).

## Operation
- Each channel is independent and identical; there is no cross-channel interaction.
- Every raw input passes through a 2-FF synchronizer. Buttons are inverted after synchronization (1 = pressed internally).
- Debounce applies per button bit. The debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts the counter. Switches (PERF, SEL) are synchronized only, not debounced.
- A press event is a debounced 0→1 transition on either button bit.
- Function code at capture:
  - FUN[2] = synchronized SEL.
  - FUN[1:0] = 01 if only BTN[0] is pressed, 10 if only BTN[1], 11 if both are pressed in the same cycle.
- Per-channel FSM:
  - IDLE: on a press event with PERF≠000, latch PERF/FUN, go to PEND. On a press event with PERF=000, pulse ERR, go to WAIT_REL.
  - PEND: REQ=1, outputs frozen; switch changes are ignored. If ACK=1, go to WAIT_REL. Further press events are ignored.
  - WAIT_REL: REQ=0. Return to IDLE once both debounced buttons read released.
- ACK is sampled only in PEND. ACK in IDLE or WAIT_REL has no effect.
- A press of the second button while the first is still held is ignored, because the FSM is not in IDLE.

## Timing
- Reset (async assert, synchronous deassert handled by top): all outputs 0, debounced buttons = released, counters 0, FSM = IDLE. Reset mid-PEND drops REQ immediately and discards the latched request.
- Latency from a raw press edge to REQ rising: 2 (sync) + DEB_CYCLES + 1 (FSM register) cycles. PERF_OUT/FUN_OUT update in the same cycle REQ rises.
- ACK sampled high in cycle n → REQ low in cycle n+1. ACK may stay high; the next request still requires release plus a new press.
- ERR is high exactly one cycle, 2 + DEB_CYCLES + 1 cycles after the raw press edge. REQ stays 0.
- A single-cycle ACK in the same cycle REQ first rises is valid and accepted.
- Release detection also requires DEB_CYCLES stable cycles, so the minimum request-to-request spacing is roughly 2·DEB_CYCLES.
- Debounce counter saturates at DEB_CYCLES; no wrap-around.

## Test plan
(All scenarios use DEB_CYCLES=4.)
- Clean press, IE01, PERF=101, SEL=0, BTN=10 (B2 pressed): REQ_IE01 rises 7 cycles after the edge, PERF_OUT=101, FUN_OUT=001. ACK pulse → REQ falls the next cycle. Release and re-press → second request.
- Bounce: BTN toggles every 2 cycles for 20 cycles, then holds low: exactly one REQ, 7 cycles after the final stable edge. No ERR.
- Invalid profile, PERF=000, press B3: ERR_IE01 one-cycle pulse, REQ_IE01 stays 0. Subsequent press with PERF=011 yields REQ with FUN_OUT={SEL,10}.
- Freeze while pending: REQ high, change PERF 101→110 and press the other button; outputs stay 101/001 until ACK. No new request until both buttons are released.
- Simultaneous: both channels press in the same cycle, BTN_IE02=00 (both bits) → FUN_OUT_IE02={SEL,11}. Both REQs rise in the same cycle; ACK only IE02 → IE01 REQ remains high.
- Reset mid-PEND: RST_N low → REQ and outputs 0 asynchronously. After release with the button still held, no request until release and re-press.

Source files
------------

// File: rtl/captura_pedidos.sv
// Per-station front end: 2-FF sync, per-button debounce, press capture into a REQ/ACK request.
// Latency: raw press edge to REQ (or ERR pulse) is 2 + DEB_CYCLES + 1 cycles.
// Backpressure: request held frozen until ACK; further presses ignored until both buttons release.
module captura_canal #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] perf_raw,
    input  logic       sel_raw,
    input  logic [1:0] btn_raw,
    input  logic       ack,
    output logic       req,
    output logic [2:0] perf_out,
    output logic [2:0] fun_out,
    output logic       err
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [2:0] perf_meta;
    logic [2:0] perf_s;
    logic       sel_meta;
    logic       sel_s;
    logic [1:0] btn_meta;
    logic [1:0] btn_sync;
    logic [1:0] sync_fill;
    logic [1:0] btn_s;

    // Button synchronizers reset to the raw released level (1) so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_meta <= '0;
            perf_s    <= '0;
            sel_meta  <= 1'b0;
            sel_s     <= 1'b0;
            btn_meta  <= 2'b11;
            btn_sync  <= 2'b11;
            sync_fill <= 2'b00;
        end else begin
            perf_meta <= perf_raw;
            perf_s    <= perf_meta;
            sel_meta  <= sel_raw;
            sel_s     <= sel_meta;
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign btn_s = ~btn_sync;

    logic [1:0] deb;
    logic [1:0] deb_q;

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (btn_s[g] != lvl) begin
                if (cnt >= CNT_W'(DEB_CYCLES - 1)) begin
                    lvl <= btn_s[g];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign deb[g] = lvl;
    end

    // A button held through reset must be seen released before any press is honoured.
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 2'b00;
            armed <= 1'b0;
        end else begin
            deb_q <= deb;
            if (sync_fill[1] && (btn_s == 2'b00) && (deb == 2'b00)) begin
                armed <= 1'b1;
            end
        end
    end

    logic [1:0] rise;
    logic       press;

    assign rise  = deb & ~deb_q;
    assign press = armed & (|rise);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            perf_out <= '0;
            fun_out  <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (perf_s != 3'b000) begin
                            req      <= 1'b1;
                            perf_out <= perf_s;
                            fun_out  <= {sel_s, rise};
                            state    <= PEND;
                        end else begin
                            err   <= 1'b1;
                            state <= WAIT_REL;
                        end
                    end
                end
                PEND: begin
                    if (ack) begin
                        req      <= 1'b0;
                        perf_out <= '0;
                        fun_out  <= '0;
                        state    <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (deb == 2'b00) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req      <= 1'b0;
                    perf_out <= '0;
                    fun_out  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// Two-station request front end: IE01 (CH7..CH4, B3/B2) and IE02 (CH3..CH0, B1/B0), fully independent.
// Latency: raw press edge to REQ_IEx (or ERR_IEx) is 2 + DEB_CYCLES + 1 cycles.
// Backpressure: each REQ_IEx holds its word until ACK_IEx; ACK outside a pending request is ignored.
module captura_pedidos #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] PERF_IE01,
    input  logic       SEL_IE01,
    input  logic [1:0] BTN_IE01,
    input  logic [2:0] PERF_IE02,
    input  logic       SEL_IE02,
    input  logic [1:0] BTN_IE02,
    input  logic       ACK_IE01,
    input  logic       ACK_IE02,
    output logic       REQ_IE01,
    output logic       REQ_IE02,
    output logic [2:0] PERF_OUT_IE01,
    output logic [2:0] PERF_OUT_IE02,
    output logic [2:0] FUN_OUT_IE01,
    output logic [2:0] FUN_OUT_IE02,
    output logic       ERR_IE01,
    output logic       ERR_IE02
);
    captura_canal #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ie01 (
        .clk      (CLK),
        .rst_n    (RST_N),
        .perf_raw (PERF_IE01),
        .sel_raw  (SEL_IE01),
        .btn_raw  (BTN_IE01),
        .ack      (ACK_IE01),
        .req      (REQ_IE01),
        .perf_out (PERF_OUT_IE01),
        .fun_out  (FUN_OUT_IE01),
        .err      (ERR_IE01)
    );

    captura_canal #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ie02 (
        .clk      (CLK),
        .rst_n    (RST_N),
        .perf_raw (PERF_IE02),
        .sel_raw  (SEL_IE02),
        .btn_raw  (BTN_IE02),
        .ack      (ACK_IE02),
        .req      (REQ_IE02),
        .perf_out (PERF_OUT_IE02),
        .fun_out  (FUN_OUT_IE02),
        .err      (ERR_IE02)
    );
endmodule

// File: tb/tb_captura_pedidos.sv
// Bench for captura_pedidos with DEB_CYCLES=4: directed scenarios plus randomized run vs. a reference model.
module tb_captura_pedidos;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] drv_perf [2];
    logic       drv_sel  [2];
    logic [1:0] drv_btn  [2];
    logic       drv_ack  [2];

    logic       REQ_IE01, REQ_IE02, ERR_IE01, ERR_IE02;
    logic [2:0] PERF_OUT_IE01, PERF_OUT_IE02, FUN_OUT_IE01, FUN_OUT_IE02;

    logic [1:0] obs_req;
    logic [1:0] obs_err;
    logic [2:0] obs_perf [2];
    logic [2:0] obs_fun  [2];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    captura_pedidos #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .PERF_IE01     (drv_perf[0]),
        .SEL_IE01      (drv_sel[0]),
        .BTN_IE01      (drv_btn[0]),
        .PERF_IE02     (drv_perf[1]),
        .SEL_IE02      (drv_sel[1]),
        .BTN_IE02      (drv_btn[1]),
        .ACK_IE01      (drv_ack[0]),
        .ACK_IE02      (drv_ack[1]),
        .REQ_IE01      (REQ_IE01),
        .REQ_IE02      (REQ_IE02),
        .PERF_OUT_IE01 (PERF_OUT_IE01),
        .PERF_OUT_IE02 (PERF_OUT_IE02),
        .FUN_OUT_IE01  (FUN_OUT_IE01),
        .FUN_OUT_IE02  (FUN_OUT_IE02),
        .ERR_IE01      (ERR_IE01),
        .ERR_IE02      (ERR_IE02)
    );

    assign obs_req     = {REQ_IE02, REQ_IE01};
    assign obs_err     = {ERR_IE02, ERR_IE01};
    assign obs_perf[0] = PERF_OUT_IE01;
    assign obs_perf[1] = PERF_OUT_IE02;
    assign obs_fun[0]  = FUN_OUT_IE01;
    assign obs_fun[1]  = FUN_OUT_IE02;

    // Reference model: raw samples delayed two edges, a debounced level that flips once the
    // last DEB synced samples all disagree with it, and a request/acknowledge mode per station.
    typedef struct packed {
        logic       vld;
        logic [1:0] pr;
        logic       sel;
        logic [2:0] perf;
    } samp_t;

    samp_t      dly     [2][2];
    logic [1:0] win     [2][DEB];
    logic [1:0] m_deb   [2];
    logic [1:0] m_prev  [2];
    bit         m_armed [2];
    int         m_mode  [2];
    logic       exp_req [2];
    logic       exp_err [2];
    logic [2:0] exp_perf[2];
    logic [2:0] exp_fun [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            dly[c][0] = '0;
            dly[c][1] = '0;
            for (int j = 0; j < DEB; j++) win[c][j] = 2'b00;
            m_deb[c] = 2'b00;  m_prev[c] = 2'b00;
            m_armed[c] = 1'b0; m_mode[c] = 0;
            exp_req[c] = 1'b0; exp_err[c] = 1'b0;
            exp_perf[c] = 3'b000; exp_fun[c] = 3'b000;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            samp_t      s;
            logic [1:0] rise;
            logic [1:0] nd;
            bit         all_diff;
            s = dly[c][1];
            rise = m_deb[c] & ~m_prev[c];
            exp_err[c] = 1'b0;
            if (m_mode[c] == 0) begin
                if (m_armed[c] && rise != 2'b00) begin
                    if (s.perf != 3'b000) begin
                        exp_req[c] = 1'b1; exp_perf[c] = s.perf; exp_fun[c] = {s.sel, rise};
                        m_mode[c] = 1;
                    end else begin
                        exp_err[c] = 1'b1;
                        m_mode[c] = 2;
                    end
                end
            end else if (m_mode[c] == 1) begin
                if (drv_ack[c]) begin
                    exp_req[c] = 1'b0; exp_perf[c] = 3'b000; exp_fun[c] = 3'b000;
                    m_mode[c] = 2;
                end
            end else if (m_deb[c] == 2'b00) begin
                m_mode[c] = 0;
            end
            if (s.vld && s.pr == 2'b00 && m_deb[c] == 2'b00) m_armed[c] = 1'b1;
            for (int j = DEB - 1; j > 0; j--) win[c][j] = win[c][j-1];
            win[c][0] = s.pr;
            nd = m_deb[c];
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) if (win[c][j][b] == m_deb[c][b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_deb[c][b];
            end
            m_prev[c] = m_deb[c];
            m_deb[c]  = nd;
            dly[c][1] = dly[c][0];
            dly[c][0] = {1'b1, ~drv_btn[c], drv_sel[c], drv_perf[c]};
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else        model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_req(input int c, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (obs_req[c] === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack_pulse(input int c);
        drv_ack[c] = 1'b1;
        cyc(1);
        drv_ack[c] = 1'b0;
    endtask

    task automatic release_btn(input int c);
        drv_btn[c] = 2'b11;
        cyc(12);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        cyc(3);
        for (int c = 0; c < 2; c++) begin
            checks++; if (obs_req[c] !== 1'b0) begin errors++; $display("FAIL reset_req ch%0d: got %b want 0", c, obs_req[c]); end
            checks++; if (obs_err[c] !== 1'b0) begin errors++; $display("FAIL reset_err ch%0d: got %b want 0", c, obs_err[c]); end
            checks++; if (obs_perf[c] !== 3'b000) begin errors++; $display("FAIL reset_perf ch%0d: got %b want 000", c, obs_perf[c]); end
            checks++; if (obs_fun[c] !== 3'b000) begin errors++; $display("FAIL reset_fun ch%0d: got %b want 000", c, obs_fun[c]); end
        end
        RST_N = 1'b1;
        cyc(6);
        checks++; if (obs_req !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", obs_req); end
    endtask

    task automatic test_clean_press();
        int lat;
        drv_perf[0] = 3'b101; drv_sel[0] = 1'b0;
        cyc(5);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL clean_latency: got %0d want %0d", lat, LAT); end
        checks++; if (obs_perf[0] !== 3'b101) begin errors++; $display("FAIL clean_perf: got %b want 101", obs_perf[0]); end
        checks++; if (obs_fun[0] !== 3'b001) begin errors++; $display("FAIL clean_fun: got %b want 001", obs_fun[0]); end
        ack_pulse(0);
        checks++; if (obs_req[0] !== 1'b0) begin errors++; $display("FAIL clean_ack_drop: got %b want 0", obs_req[0]); end
        release_btn(0);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL clean_second_latency: got %0d want %0d", lat, LAT); end
        ack_pulse(0);
        release_btn(0);
    endtask

    task automatic test_bounce();
        int bad_req = 0;
        int errs = 0;
        int lat;
        int extra = 0;
        for (int i = 0; i < 10; i++) begin
            drv_btn[0] = (i % 2 == 0) ? 2'b10 : 2'b11;
            repeat (2) begin
                @(negedge CLK);
                if (obs_req[0] !== 1'b0) bad_req++;
                if (obs_err[0] !== 1'b0) errs++;
            end
        end
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        checks++; if (bad_req !== 0) begin errors++; $display("FAIL bounce_early_req: got %0d cycles want 0", bad_req); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bounce_latency: got %0d want %0d", lat, LAT); end
        ack_pulse(0);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (obs_req[0] !== 1'b0) extra++;
            if (obs_err[0] !== 1'b0) errs++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bounce_single_req: got %0d extra cycles want 0", extra); end
        checks++; if (errs !== 0) begin errors++; $display("FAIL bounce_err: got %0d pulses want 0", errs); end
        release_btn(0);
    endtask

    task automatic test_invalid_profile();
        int err_cnt = 0;
        int err_at = -1;
        int req_cnt = 0;
        int lat;
        drv_perf[0] = 3'b000; drv_sel[0] = 1'b1;
        cyc(5);
        drv_btn[0] = 2'b01;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            if (obs_err[0] === 1'b1) begin err_cnt++; err_at = i; end
            if (obs_req[0] !== 1'b0) req_cnt++;
        end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL invalid_err_width: got %0d cycles want 1", err_cnt); end
        checks++; if (err_at !== LAT) begin errors++; $display("FAIL invalid_err_time: got %0d want %0d", err_at, LAT); end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL invalid_no_req: got %0d cycles want 0", req_cnt); end
        release_btn(0);
        drv_perf[0] = 3'b011;
        cyc(3);
        drv_btn[0] = 2'b01;
        wait_req(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL invalid_retry_latency: got %0d want %0d", lat, LAT); end
        checks++; if (obs_perf[0] !== 3'b011) begin errors++; $display("FAIL invalid_retry_perf: got %b want 011", obs_perf[0]); end
        checks++; if (obs_fun[0] !== 3'b110) begin errors++; $display("FAIL invalid_retry_fun: got %b want 110", obs_fun[0]); end
        ack_pulse(0);
        release_btn(0);
    endtask

    task automatic test_freeze();
        int lat;
        int bad = 0;
        int req_cnt = 0;
        drv_perf[0] = 3'b101; drv_sel[0] = 1'b0;
        cyc(5);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        drv_perf[0] = 3'b110;
        drv_btn[0] = 2'b00;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (obs_req[0] !== 1'b1 || obs_perf[0] !== 3'b101 || obs_fun[0] !== 3'b001) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL freeze_outputs: got %0d changed cycles want 0", bad); end
        ack_pulse(0);
        checks++; if (obs_req[0] !== 1'b0) begin errors++; $display("FAIL freeze_ack_drop: got %b want 0", obs_req[0]); end
        drv_btn[0] = 2'b01;
        cyc(12);
        drv_btn[0] = 2'b00;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (obs_req[0] !== 1'b0) req_cnt++;
        end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL freeze_no_req_while_held: got %0d cycles want 0", req_cnt); end
        release_btn(0);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL freeze_next_latency: got %0d want %0d", lat, LAT); end
        checks++; if (obs_perf[0] !== 3'b110) begin errors++; $display("FAIL freeze_next_perf: got %b want 110", obs_perf[0]); end
        ack_pulse(0);
        release_btn(0);
    endtask

    task automatic test_simultaneous();
        int l0 = -1;
        int l1 = -1;
        drv_perf[0] = 3'b101; drv_sel[0] = 1'b1;
        drv_perf[1] = 3'b010; drv_sel[1] = 1'b1;
        cyc(5);
        drv_btn[0] = 2'b10;
        drv_btn[1] = 2'b00;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (obs_req[0] === 1'b1 && l0 < 0) l0 = i;
            if (obs_req[1] === 1'b1 && l1 < 0) l1 = i;
            if (l0 >= 0 && l1 >= 0) break;
        end
        checks++; if (l0 !== LAT) begin errors++; $display("FAIL simul_lat_ie01: got %0d want %0d", l0, LAT); end
        checks++; if (l1 !== LAT) begin errors++; $display("FAIL simul_lat_ie02: got %0d want %0d", l1, LAT); end
        checks++; if (obs_fun[1] !== 3'b111) begin errors++; $display("FAIL simul_fun_ie02: got %b want 111", obs_fun[1]); end
        checks++; if (obs_perf[1] !== 3'b010) begin errors++; $display("FAIL simul_perf_ie02: got %b want 010", obs_perf[1]); end
        checks++; if (obs_fun[0] !== 3'b101) begin errors++; $display("FAIL simul_fun_ie01: got %b want 101", obs_fun[0]); end
        ack_pulse(1);
        checks++; if (obs_req !== 2'b01) begin errors++; $display("FAIL simul_ack_ie02_only: got %b want 01", obs_req); end
        cyc(5);
        checks++; if (obs_req[0] !== 1'b1) begin errors++; $display("FAIL simul_ie01_holds: got %b want 1", obs_req[0]); end
        ack_pulse(0);
        drv_btn[1] = 2'b11;
        release_btn(0);
    endtask

    task automatic test_reset_mid_pend();
        int lat;
        int req_cnt = 0;
        drv_perf[0] = 3'b101; drv_sel[0] = 1'b0;
        cyc(3);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        cyc(2);
        #2 RST_N = 1'b0;
        #1;
        checks++; if (obs_req[0] !== 1'b0) begin errors++; $display("FAIL rst_pend_req: got %b want 0", obs_req[0]); end
        checks++; if (obs_perf[0] !== 3'b000) begin errors++; $display("FAIL rst_pend_perf: got %b want 000", obs_perf[0]); end
        checks++; if (obs_fun[0] !== 3'b000) begin errors++; $display("FAIL rst_pend_fun: got %b want 000", obs_fun[0]); end
        cyc(3);
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (obs_req[0] !== 1'b0) req_cnt++;
        end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL rst_held_no_req: got %0d cycles want 0", req_cnt); end
        release_btn(0);
        drv_btn[0] = 2'b10;
        wait_req(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_repress_latency: got %0d want %0d", lat, LAT); end
        ack_pulse(0);
        release_btn(0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLK);
            for (int c = 0; c < 2; c++) begin
                checks++; if (obs_req[c] !== exp_req[c]) begin errors++; $display("FAIL rand_req ch%0d cyc%0d: got %b want %b", c, n, obs_req[c], exp_req[c]); end
                checks++; if (obs_err[c] !== exp_err[c]) begin errors++; $display("FAIL rand_err ch%0d cyc%0d: got %b want %b", c, n, obs_err[c], exp_err[c]); end
                checks++; if (obs_perf[c] !== exp_perf[c]) begin errors++; $display("FAIL rand_perf ch%0d cyc%0d: got %b want %b", c, n, obs_perf[c], exp_perf[c]); end
                checks++; if (obs_fun[c] !== exp_fun[c]) begin errors++; $display("FAIL rand_fun ch%0d cyc%0d: got %b want %b", c, n, obs_fun[c], exp_fun[c]); end
            end
            for (int c = 0; c < 2; c++) begin
                int b;
                if ($urandom_range(0, 7) == 0) begin
                    b = int'($urandom_range(0, 1));
                    drv_btn[c][b] = ~drv_btn[c][b];
                end
                if ($urandom_range(0, 29) == 0) drv_perf[c] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 29) == 0) drv_sel[c] = ~drv_sel[c];
                drv_ack[c] = ($urandom_range(0, 3) == 0);
            end
            if (n == 2003) RST_N = 1'b1;
            if (n == 2000) #2 RST_N = 1'b0;
        end
        drv_ack[0] = 1'b0;
        drv_ack[1] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            drv_perf[c] = 3'b000;
            drv_sel[c]  = 1'b0;
            drv_btn[c]  = 2'b11;
            drv_ack[c]  = 1'b0;
        end
        test_reset();
        test_clean_press();
        test_bounce();
        test_invalid_profile();
        test_freeze();
        test_simultaneous();
        test_reset_mid_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
